// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// A single full_subtractor cell is reused every cycle, and a registered borrow
// is fed back into it. The handshake is start/busy/done.
// Optional build macro SERIAL_SUBTRACTOR_OVERFLOW_EN adds a registered
// two's-complement overflow output.

// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // purely combinational difference/borrow
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrow_out
);
    // one extra bit so the counter can never wrap within an operation
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // control FSM, operand/result shifters and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        brw    <= borrow_in;
                        cnt    <= '0;
                        res_sr <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= {cell_d, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    brw    <= cell_bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // only the completed word ever reaches the output port
                        difference <= {cell_d, res_sr[WIDTH-1:1]};
                        borrow_out <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        // borrow into MSB differs from borrow out of MSB
                        overflow   <= brw ^ cell_bout;
`endif
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: begin
                    // start is deliberately ignored here
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
